// File: rtl/io_mmio_uart_if.sv
// CPU-side MMIO bus plus UART receiver/transmitter handshakes for io_mmio_uart_fifo.
// The slave modport is the I/O block's view; master is the CPU/UART side.
interface io_mmio_uart_if;
  logic [7:0]  io_addr;
  logic        io_re;
  logic        io_we;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        inst_retire;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;

  modport slave (
    input  io_addr, io_re, io_we, io_wdata, inst_retire,
    input  uart_rx_data, uart_rx_valid, uart_tx_ready,
    output io_rdata, uart_rx_ready, uart_tx_data, uart_tx_valid
  );

  modport master (
    output io_addr, io_re, io_we, io_wdata, inst_retire,
    output uart_rx_data, uart_rx_valid, uart_tx_ready,
    input  io_rdata, uart_rx_ready, uart_tx_data, uart_tx_valid
  );
endinterface

// File: rtl/io_mmio_uart_fifo.sv
// Memory-mapped UART block: RX/TX byte FIFOs, overflow/drop tracking, cycle and
// instret counters, with a registered one-cycle read path.
module io_mmio_uart_fifo #(
  parameter int RX_DEPTH  = 16,
  parameter int TX_DEPTH  = 16,
  parameter int CNT_WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  io_mmio_uart_if.slave bus
);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_CW = RX_AW + 1;
  localparam int TX_CW = TX_AW + 1;
  localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);
  localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);

  localparam logic [5:0] A_STAT    = 6'h00;
  localparam logic [5:0] A_RXDATA  = 6'h01;
  localparam logic [5:0] A_TXDATA  = 6'h02;
  localparam logic [5:0] A_COUNT   = 6'h03;
  localparam logic [5:0] A_CYCLE   = 6'h04;
  localparam logic [5:0] A_INSTRET = 6'h05;
  localparam logic [5:0] A_CNTCLR  = 6'h06;
  localparam logic [5:0] A_ERR     = 6'h07;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [7:0]           rx_mem_q [RX_DEPTH];
  logic [7:0]           tx_mem_q [TX_DEPTH];
  logic [RX_AW-1:0]     rx_rd_ptr_q, rx_rd_ptr_d, rx_wr_ptr_q, rx_wr_ptr_d;
  logic [TX_AW-1:0]     tx_rd_ptr_q, tx_rd_ptr_d, tx_wr_ptr_q, tx_wr_ptr_d;
  logic [RX_CW-1:0]     rx_count_q, rx_count_d;
  logic [TX_CW-1:0]     tx_count_q, tx_count_d;
  logic [15:0]          rx_drop_q, rx_drop_d;
  logic                 tx_ovf_q, tx_ovf_d;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d, instret_q, instret_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rx_ready_q, rx_ready_d;

  logic [5:0] word;
  logic       rx_full, tx_full, rx_avail, tx_avail;
  logic       rx_pop, rx_push, rx_drop_ev;
  logic       tx_pop, tx_push, tx_wr, tx_ovf_ev;
  logic       cnt_clr, err_clr;
  logic       unused_bits;

  assign word        = bus.io_addr[7:2];
  assign unused_bits = ^{bus.io_addr[1:0], bus.io_wdata[31:8]};

  always_comb begin
    rx_full    = (rx_count_q == RX_FULL);
    tx_full    = (tx_count_q == TX_FULL);
    rx_avail   = (rx_count_q != '0);
    tx_avail   = (tx_count_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    rx_pop     = bus.io_re && (word == A_RXDATA) && rx_avail;
    rx_push    = bus.uart_rx_valid && rx_ready_q && (!rx_full || rx_pop);
    rx_drop_ev = bus.uart_rx_valid && rx_ready_q && rx_full && !rx_pop;
    tx_pop     = tx_avail && bus.uart_tx_ready;
    tx_wr      = bus.io_we && (word == A_TXDATA);
    tx_push    = tx_wr && (!tx_full || tx_pop);
    tx_ovf_ev  = tx_wr && tx_full && !tx_pop;
    cnt_clr    = bus.io_we && (word == A_CNTCLR);
    err_clr    = bus.io_we && (word == A_ERR);

    rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + RX_AW'(1) : rx_rd_ptr_q;
    rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + RX_AW'(1) : rx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + TX_AW'(1) : tx_rd_ptr_q;
    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + TX_AW'(1) : tx_wr_ptr_q;

    rx_count_d = rx_count_q;
    if (rx_push && !rx_pop)      rx_count_d = rx_count_q + RX_CW'(1);
    else if (!rx_push && rx_pop) rx_count_d = rx_count_q - RX_CW'(1);
    tx_count_d = tx_count_q;
    if (tx_push && !tx_pop)      tx_count_d = tx_count_q + TX_CW'(1);
    else if (!tx_push && tx_pop) tx_count_d = tx_count_q - TX_CW'(1);

    // Clears win over a same-cycle drop, overflow or increment.
    rx_drop_d = err_clr ? 16'd0 : (rx_drop_ev ? sat_inc16(rx_drop_q) : rx_drop_q);
    tx_ovf_d  = err_clr ? 1'b0  : (tx_ovf_q | tx_ovf_ev);
    cycle_d   = cnt_clr ? '0 : cycle_q + CNT_WIDTH'(1);
    instret_d = cnt_clr ? '0 : (bus.inst_retire ? instret_q + CNT_WIDTH'(1) : instret_q);
    rx_ready_d = 1'b1;

    // Counter reads report the value including the read cycle itself.
    rdata_d = rdata_q;
    if (bus.io_re) begin
      case (word)
        A_STAT:    rdata_d = {30'b0, rx_avail, !tx_full};
        A_RXDATA:  rdata_d = rx_avail ? {24'b0, rx_mem_q[rx_rd_ptr_q]} : 32'b0;
        A_COUNT:   rdata_d = {16'(rx_count_q), 16'(tx_count_q)};
        A_CYCLE:   rdata_d = 32'(cycle_d);
        A_INSTRET: rdata_d = 32'(instret_d);
        A_ERR:     rdata_d = {tx_ovf_q, 15'b0, rx_drop_q};
        default:   rdata_d = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_rd_ptr_q <= '0;
      rx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_wr_ptr_q <= '0;
      rx_count_q  <= '0;
      tx_count_q  <= '0;
      rx_drop_q   <= '0;
      tx_ovf_q    <= 1'b0;
      cycle_q     <= '0;
      instret_q   <= '0;
      rdata_q     <= '0;
      rx_ready_q  <= 1'b0;
    end else begin
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      rx_count_q  <= rx_count_d;
      tx_count_q  <= tx_count_d;
      rx_drop_q   <= rx_drop_d;
      tx_ovf_q    <= tx_ovf_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
      rdata_q     <= rdata_d;
      rx_ready_q  <= rx_ready_d;
    end
  end

  // Storage is not reset; pointers and counts alone define validity.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= bus.uart_rx_data;
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= bus.io_wdata[7:0];
  end

  assign bus.io_rdata      = rdata_q;
  assign bus.uart_rx_ready = rx_ready_q;
  assign bus.uart_tx_valid = tx_avail;
  assign bus.uart_tx_data  = tx_mem_q[tx_rd_ptr_q];
endmodule

// File: tb/tb_io_mmio_uart_fifo.sv
// Bench for io_mmio_uart_fifo: queue-based reference model, scoreboard monitor,
// directed scenarios followed by randomized MMIO/UART traffic.
module tb_io_mmio_uart_fifo;
  localparam int RX_DEPTH = 16;
  localparam int TX_DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  io_mmio_uart_if bus();

  io_mmio_uart_fifo #(.RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH), .CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state, advanced once per clock edge by the driver.
  logic [7:0]  rxq[$];
  int          tx_cnt  = 0;
  bit          tx_ovf  = 0;
  int          rx_drop = 0;
  logic [31:0] cyc     = 0;
  logic [31:0] inst    = 0;
  bit          rdy     = 0;

  // Scoreboard queues consumed by the monitor.
  logic [31:0] exp_rd[$];
  logic [7:0]  exp_tx[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_edge();
    logic [5:0]  w;
    logic [31:0] rv;
    bit rpop, tpop, clr_cnt, clr_err, ovf_ev, drop_ev;
    w = bus.io_addr[7:2];
    if (rst) begin
      exp_rd.push_back(32'd0);
      rxq.delete();
      exp_tx.delete();
      tx_cnt = 0; tx_ovf = 0; rx_drop = 0; cyc = 0; inst = 0; rdy = 0;
      return;
    end
    clr_cnt = bus.io_we && (w == 6'd6);
    clr_err = bus.io_we && (w == 6'd7);
    rpop    = bus.io_re && (w == 6'd1) && (rxq.size() > 0);
    tpop    = (tx_cnt > 0) && bus.uart_tx_ready;
    ovf_ev  = 0;
    drop_ev = 0;
    if (bus.io_re) begin
      case (w)
        6'd0:    rv = {30'b0, rxq.size() != 0, tx_cnt < TX_DEPTH};
        6'd1:    rv = (rxq.size() > 0) ? {24'b0, rxq[0]} : 32'd0;
        6'd3:    rv = (32'(rxq.size()) << 16) | 32'(tx_cnt);
        6'd4:    rv = clr_cnt ? 32'd0 : cyc + 32'd1;
        6'd5:    rv = clr_cnt ? 32'd0 : inst + (bus.inst_retire ? 32'd1 : 32'd0);
        6'd7:    rv = {tx_ovf, 15'b0, 16'(rx_drop)};
        default: rv = 32'd0;
      endcase
      exp_rd.push_back(rv);
    end
    if (rpop) void'(rxq.pop_front());
    if (rdy && bus.uart_rx_valid) begin
      if (rxq.size() < RX_DEPTH) rxq.push_back(bus.uart_rx_data);
      else drop_ev = 1;
    end
    if (tpop) tx_cnt--;
    if (bus.io_we && (w == 6'd2)) begin
      if (tx_cnt < TX_DEPTH) begin
        exp_tx.push_back(bus.io_wdata[7:0]);
        tx_cnt++;
      end else ovf_ev = 1;
    end
    tx_ovf  = clr_err ? 1'b0 : (tx_ovf | ovf_ev);
    rx_drop = clr_err ? 0 : ((drop_ev && rx_drop < 65535) ? rx_drop + 1 : rx_drop);
    cyc     = clr_cnt ? 32'd0 : cyc + 32'd1;
    inst    = clr_cnt ? 32'd0 : inst + (bus.inst_retire ? 32'd1 : 32'd0);
    rdy     = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    bus.io_re         = 1'b0;
    bus.io_we         = 1'b0;
    bus.uart_rx_valid = 1'b0;
    bus.inst_retire   = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.io_we = 1'b1; bus.io_addr = a; bus.io_wdata = d;
    tick();
  endtask

  task automatic peek(input logic [7:0] a, input logic [31:0] e, input string nm);
    bus.io_re = 1'b1; bus.io_addr = a;
    tick();
    check(nm, bus.io_rdata, e);
  endtask

  task automatic inject(input logic [7:0] d);
    bus.uart_rx_valid = 1'b1; bus.uart_rx_data = d;
    tick();
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  bit          armed   = 0;
  bit          rd_pend = 0;
  logic [31:0] last_rd = 0;
  always @(negedge clk) begin
    if (armed) begin
      if (rd_pend) begin
        if (exp_rd.size() == 0) begin
          checks++;
          $display("FAIL rdata_sb: got %h with no expected value queued", bus.io_rdata);
        end else begin
          last_rd = exp_rd.pop_front();
          check("rdata", bus.io_rdata, last_rd);
        end
      end else begin
        check("rdata_hold", bus.io_rdata, last_rd);
      end
      check("tx_valid", 32'(bus.uart_tx_valid), 32'(tx_cnt > 0));
      check("rx_ready", 32'(bus.uart_rx_ready), 32'(rdy));
      if (bus.uart_tx_valid) begin
        if (exp_tx.size() == 0) begin
          checks++;
          $display("FAIL tx_sb: byte %h presented with no expected byte", bus.uart_tx_data);
        end else begin
          check("tx_data", 32'(bus.uart_tx_data), 32'(exp_tx[0]));
          if (bus.uart_tx_ready) void'(exp_tx.pop_front());
        end
      end
    end
    rd_pend = bus.io_re || rst;
    armed   = 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.io_addr = '0; bus.io_re = 0; bus.io_we = 0; bus.io_wdata = '0;
    bus.inst_retire = 0; bus.uart_rx_data = '0; bus.uart_rx_valid = 0; bus.uart_tx_ready = 0;
    @(negedge clk);
    repeat (3) tick();
    check("rdata_reset", bus.io_rdata, 32'd0);
    check("rx_ready_in_reset", 32'(bus.uart_rx_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("rx_ready_after_reset", 32'(bus.uart_rx_ready), 32'd1);
    check("tx_valid_after_reset", 32'(bus.uart_tx_valid), 32'd0);
    peek(8'h00, 32'h1, "status_reset");
    peek(8'h04, 32'h0, "rx_empty_read");

    // TX held off, then drained in order
    bus.uart_tx_ready = 0;
    wr(8'h08, 32'h41); wr(8'h08, 32'h42); wr(8'h08, 32'h43);
    peek(8'h0C, 32'h3, "tx_count3");
    repeat (3) tick();
    check("tx_head_stable", 32'(bus.uart_tx_data), 32'h41);
    bus.uart_tx_ready = 1;
    for (int i = 0; i < 3; i++) begin
      check("tx_order", 32'(bus.uart_tx_data), 32'h41 + 32'(i));
      tick();
    end
    check("tx_drained", 32'(bus.uart_tx_valid), 32'd0);
    bus.uart_tx_ready = 0;

    // RX overflow with drop counting
    for (int i = 0; i < RX_DEPTH + 3; i++) inject(8'h10 + 8'(i));
    peek(8'h00, 32'h3, "status_rx_nonempty");
    peek(8'h0C, 32'(RX_DEPTH) << 16, "rx_count_full");
    peek(8'h1C, 32'h0000_0003, "rx_drop3");
    for (int i = 0; i < RX_DEPTH; i++) peek(8'h04, 32'h10 + 32'(i), "rx_order");
    peek(8'h04, 32'h0, "rx_empty_again");
    wr(8'h1C, 32'h0);
    peek(8'h1C, 32'h0, "err_cleared");

    // TX overflow, then pop+push on a full FIFO
    for (int i = 0; i < TX_DEPTH; i++) wr(8'h08, 32'h80 + 32'(i));
    wr(8'h08, 32'hFF);
    peek(8'h1C, 32'h8000_0000, "tx_ovf");
    peek(8'h00, 32'h0, "status_tx_full");
    bus.uart_tx_ready = 1;
    wr(8'h08, 32'h5A);
    bus.uart_tx_ready = 0;
    peek(8'h0C, 32'(TX_DEPTH), "tx_full_pop_push");
    bus.uart_tx_ready = 1;
    for (int i = 1; i < TX_DEPTH; i++) begin
      check("tx_full_order", 32'(bus.uart_tx_data), 32'h80 + 32'(i));
      tick();
    end
    check("tx_appended_last", 32'(bus.uart_tx_data), 32'h5A);
    tick();
    check("tx_drained2", 32'(bus.uart_tx_valid), 32'd0);
    bus.uart_tx_ready = 0;
    wr(8'h1C, 32'h0);

    // Counters
    wr(8'h18, 32'hDEAD_BEEF);
    for (int i = 0; i < 20; i++) begin
      bus.inst_retire = (i % 2 == 0);
      tick();
    end
    peek(8'h14, 32'd10, "instret10");
    wr(8'h18, 32'h0);
    peek(8'h10, 32'd1, "cycle_after_clear");
    peek(8'h20, 32'h0, "unmapped_read");

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 9);
      bus.io_addr       = (r < 8) ? 8'(r * 4) : ((r == 8) ? 8'h20 : 8'h3D);
      bus.io_re         = ($urandom_range(0, 2) == 0);
      bus.io_we         = ($urandom_range(0, 3) == 0);
      bus.io_wdata      = $urandom;
      bus.uart_rx_valid = ($urandom_range(0, 1) == 1);
      bus.uart_rx_data  = 8'($urandom);
      bus.uart_tx_ready = ($urandom_range(0, 3) == 0);
      bus.inst_retire   = ($urandom_range(0, 1) == 1);
      tick();
    end

    // Reset in the middle of operation
    bus.uart_tx_ready = 0;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int i = 0; i < 5; i++) wr(8'h08, 32'hA0 + 32'(i));
    for (int i = 0; i < 5; i++) inject(8'hC0 + 8'(i));
    peek(8'h0C, 32'h0005_0005, "counts_before_rst");
    rst = 1'b1;
    bus.io_re = 1'b1; bus.io_addr = 8'h04;
    tick();
    check("rdata_mid_rst", bus.io_rdata, 32'd0);
    check("tx_valid_mid_rst", 32'(bus.uart_tx_valid), 32'd0);
    rst = 1'b0;
    tick();
    peek(8'h0C, 32'h0, "counts_after_rst");
    peek(8'h14, 32'h0, "instret_after_rst");
    peek(8'h04, 32'h0, "rx_after_rst");
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
